// File: rtl/lru_assoc_cache_ctrl.sv
// lru_assoc_cache_ctrl: fully-associative true-LRU cache controller with backend refill, flush and hit/miss counters
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   req_valid/req_ready/req_tag       frontend lookup request
//   rsp_valid/rsp_ready/rsp_data/rsp_hit  frontend response (line, served-from-cache flag)
//   mem_req_valid/mem_req_ready/mem_req_tag  backend fetch request
//   mem_rsp_valid/mem_rsp_ready/mem_rsp_data backend line return
//   flush/flush_done                  invalidate-all request and completion pulse
//   hit_cnt/miss_cnt                  saturating statistics
module lru_assoc_cache_ctrl #(
    parameter int TAG_W  = 48,
    parameter int DATA_W = 512,
    parameter int WAYS   = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [TAG_W-1:0]  mem_req_tag,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              flush,
    output logic              flush_done,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int IDX_W = $clog2(WAYS);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_RESP   = 3'd2;
    localparam logic [2:0] S_MREQ   = 3'd3;
    localparam logic [2:0] S_MWAIT  = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [WAYS-1:0]   valid_q, valid_d;
    logic [IDX_W-1:0]  rank_q [WAYS];
    logic [IDX_W-1:0]  rank_d [WAYS];
    logic [TAG_W-1:0]  tag_arr_q [WAYS];
    logic [DATA_W-1:0] data_arr_q [WAYS];
    logic [TAG_W-1:0]  tag_l_q, tag_l_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic              flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0]  victim_q, victim_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic              hit, any_free, refill, touch;
    logic [IDX_W-1:0]  hit_way, free_way, use_way, use_pos;

    assign req_ready     = state_q == S_IDLE && !flush_pend_q;
    assign rsp_valid     = state_q == S_RESP;
    assign rsp_data      = rsp_data_q;
    assign rsp_hit       = rsp_hit_q;
    assign mem_req_valid = state_q == S_MREQ;
    assign mem_req_tag   = tag_l_q;
    // a beat offered while reset is asserted must not be consumed
    assign mem_rsp_ready = rstn && state_q == S_MWAIT;
    assign flush_done    = state_q == S_FLUSH;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

    assign refill  = mem_rsp_ready && mem_rsp_valid;
    assign touch   = (state_q == S_LOOKUP && hit) || refill;
    assign use_way = refill ? victim_q : hit_way;

    // descending scan leaves the lowest-index invalid way in free_way
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        any_free = 1'b0;
        free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_way = IDX_W'(i);
            end
            if (valid_q[i] && tag_arr_q[i] == tag_l_q) begin
                hit     = 1'b1;
                hit_way = IDX_W'(i);
            end
        end
    end

    // move the used way to rank[0]; everything ahead of it shifts back one slot
    always_comb begin
        use_pos = '0;
        for (int i = 0; i < WAYS; i++)
            if (rank_q[i] == use_way) use_pos = IDX_W'(i);
        rank_d[0] = state_q == S_FLUSH ? '0 : touch ? use_way : rank_q[0];
        for (int i = 1; i < WAYS; i++)
            rank_d[i] = state_q == S_FLUSH ? IDX_W'(i) :
                        (touch && i <= int'(use_pos)) ? rank_q[i-1] : rank_q[i];
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_l_d      = tag_l_q;
        rsp_data_d   = rsp_data_q;
        rsp_hit_d    = rsp_hit_q;
        victim_d     = victim_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        flush_pend_d = state_q == S_FLUSH ? 1'b0 : flush_pend_q || flush;
        case (state_q)
            S_IDLE: begin
                if (flush_pend_q) begin
                    state_d = S_FLUSH;
                end else if (req_valid) begin
                    tag_l_d = req_tag;
                    state_d = S_LOOKUP;
                end
            end
            S_FLUSH: begin
                valid_d = '0;
                state_d = S_IDLE;
            end
            S_LOOKUP: begin
                if (hit) begin
                    rsp_data_d = data_arr_q[hit_way];
                    rsp_hit_d  = 1'b1;
                    hit_cnt_d  = hit_cnt_q + CNT_W'(hit_cnt_q != '1);
                    state_d    = S_RESP;
                end else begin
                    miss_cnt_d = miss_cnt_q + CNT_W'(miss_cnt_q != '1);
                    victim_d   = any_free ? free_way : rank_q[WAYS-1];
                    state_d    = S_MREQ;
                end
            end
            S_MREQ: state_d = mem_req_ready ? S_MWAIT : S_MREQ;
            S_MWAIT: begin
                if (refill) begin
                    valid_d[victim_q] = 1'b1;
                    rsp_data_d        = mem_rsp_data;
                    rsp_hit_d         = 1'b0;
                    state_d           = S_RESP;
                end
            end
            S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            tag_l_q      <= '0;
            rsp_data_q   <= '0;
            rsp_hit_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            victim_q     <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int i = 0; i < WAYS; i++) rank_q[i] <= IDX_W'(i);
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_l_q      <= tag_l_d;
            rsp_data_q   <= rsp_data_d;
            rsp_hit_q    <= rsp_hit_d;
            flush_pend_q <= flush_pend_d;
            victim_q     <= victim_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            for (int i = 0; i < WAYS; i++) rank_q[i] <= rank_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (refill) begin
            tag_arr_q[victim_q]  <= tag_l_q;
            data_arr_q[victim_q] <= mem_rsp_data;
        end
    end
endmodule

// File: tb/tb_lru_assoc_cache_ctrl.sv
// tb_lru_assoc_cache_ctrl: randomized and directed check of the LRU cache controller against a behavioural model
module tb_lru_assoc_cache_ctrl;
    localparam int TAG_W = 16, DATA_W = 32, WAYS = 8, CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0, rstn;
    logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_hit;
    logic mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
    logic flush, flush_done;
    logic [TAG_W-1:0] req_tag, mem_req_tag;
    logic [DATA_W-1:0] rsp_data, mem_rsp_data;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    lru_assoc_cache_ctrl #(.TAG_W(TAG_W), .DATA_W(DATA_W), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .flush(flush), .flush_done(flush_done), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int mreq_delay = 0, mrsp_delay = 0, fetches = 0;
    bit chk_en = 0, txn_active = 0;

    // model: per-way contents plus a recency list of way numbers, most recent first
    bit              mv [WAYS];
    logic [TAG_W-1:0] mt [WAYS];
    int              order [$];
    int              hc = 0, mc = 0;
    bit              exp_hit;
    logic [TAG_W-1:0] exp_tag;
    logic [DATA_W-1:0] exp_data;

    function automatic logic [DATA_W-1:0] line_of(input logic [TAG_W-1:0] t);
        return {t, t ^ 16'hA5A5};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    endtask

    task automatic model_flush();
        order.delete();
        for (int i = 0; i < WAYS; i++) begin
            mv[i] = 0;
            order.push_back(i);
        end
    endtask

    task automatic model_access(input logic [TAG_W-1:0] tag);
        int w = -1;
        for (int i = 0; i < WAYS; i++) if (mv[i] && mt[i] == tag) w = i;
        exp_hit  = w >= 0;
        exp_tag  = tag;
        exp_data = line_of(tag);
        if (exp_hit) hc = hc == CMAX ? CMAX : hc + 1;
        else begin
            mc = mc == CMAX ? CMAX : mc + 1;
            for (int i = WAYS - 1; i >= 0; i--) if (!mv[i]) w = i;
            if (w < 0) w = order[WAYS-1];
            mv[w] = 1;
            mt[w] = tag;
        end
        for (int k = 0; k < order.size(); k++)
            if (order[k] == w) begin
                order.delete(k);
                break;
            end
        order.push_front(w);
    endtask

    always @(negedge clk) begin
        if (rstn && chk_en) begin
            if (txn_active) begin
                if (rsp_valid) begin
                    chk("rsp_hit", rsp_hit, exp_hit);
                    chk("rsp_data", rsp_data, exp_data);
                    chk("hit_cnt_rsp", hit_cnt, hc);
                    chk("miss_cnt_rsp", miss_cnt, mc);
                end
                if (mem_req_valid) begin
                    chk("fetch_on_hit", exp_hit, 0);
                    chk("mem_req_tag", mem_req_tag, exp_tag);
                end
                chk("flush_done_busy", flush_done, 0);
            end else begin
                chk("idle_rsp_valid", rsp_valid, 0);
                chk("idle_mem_req", mem_req_valid, 0);
                chk("hit_cnt_idle", hit_cnt, hc);
                chk("miss_cnt_idle", miss_cnt, mc);
            end
        end
    end

    logic [TAG_W-1:0] be_tag;
    bit be_go;
    int be_n;
    initial begin
        mem_req_ready = 0;
        mem_rsp_valid = 0;
        mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_valid) begin
                be_go = 1;
                for (int k = 0; k < mreq_delay; k++) begin
                    @(posedge clk);
                    #1;
                    if (!mem_req_valid) begin
                        be_go = 0;
                        break;
                    end
                end
                if (be_go) begin
                    be_tag = mem_req_tag;
                    mem_req_ready = 1;
                    @(posedge clk);
                    fetches++;
                    #1 mem_req_ready = 0;
                    for (int k = 0; k < mrsp_delay; k++) begin
                        @(posedge clk);
                        #1;
                    end
                    mem_rsp_valid = 1;
                    mem_rsp_data  = line_of(be_tag);
                    be_n = 0;
                    do begin
                        @(negedge clk);
                        be_n++;
                    end while (!mem_rsp_ready && rstn && be_n < 500);
                    if (be_n >= 500) chk("mem_rsp_wait", 0, 1);
                    @(posedge clk);
                    #1 mem_rsp_valid = 0;
                end
            end
        end
    end

    task automatic do_req(input logic [TAG_W-1:0] tag, input int hold, output bit got_hit, output logic [DATA_W-1:0] got_data);
        int n, f0;
        got_hit  = 0;
        got_data = '0;
        req_tag   = tag;
        req_valid = 1;
        rsp_ready = hold == 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) begin
            chk("req_ready_timeout", 0, 1);
            req_valid = 0;
            rsp_ready = 1;
            return;
        end
        @(posedge clk);
        model_access(tag);
        f0 = fetches;
        txn_active = 1;
        #1 req_valid = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 300);
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            txn_active = 0;
            rsp_ready = 1;
            return;
        end
        got_hit  = rsp_hit;
        got_data = rsp_data;
        if (exp_hit) chk("hit_latency", n, 2);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 rsp_ready = 1;
            @(negedge clk);
        end
        chk("rsp_handshake", rsp_valid && rsp_ready, 1);
        @(posedge clk);
        txn_active = 0;
        chk("fetch_count", fetches - f0, exp_hit ? 0 : 1);
        #1;
    endtask

    bit h;
    logic [DATA_W-1:0] d;
    int n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 0; req_valid = 0; req_tag = '0; rsp_ready = 1; flush = 0;
        model_flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_rsp_ready", mem_rsp_ready, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        @(posedge clk);
        #1 rstn = 1;
        chk_en = 1;

        for (int i = 0; i < 8; i++) begin
            do_req(16'h10 + 16'(i), 0, h, d);
            chk("cold_miss", h, 0);
        end
        chk("cold_miss_cnt", miss_cnt, 8);

        do_req(16'h10, 0, h, d);
        chk("rereq_hit", h, 1);
        chk("rereq_data", d, 32'h0010A5B5);
        chk("rereq_hit_cnt", hit_cnt, 1);

        do_req(16'h20, 0, h, d);
        chk("evict_new_miss", h, 0);
        do_req(16'h11, 0, h, d);
        chk("evicted_lru_miss", h, 0);
        do_req(16'h10, 0, h, d);
        chk("mru_kept_hit", h, 1);

        mreq_delay = 5;
        do_req(16'h50, 4, h, d);
        chk("bp_miss", h, 0);
        chk("bp_miss_data", d, 32'h0050A5F5);
        mreq_delay = 0;
        do_req(16'h50, 4, h, d);
        chk("bp_hit", h, 1);

        mrsp_delay = 6;
        fork
            do_req(16'h40, 0, h, d);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!mem_rsp_ready && n < 100);
                @(posedge clk);
                #1 flush = 1;
                @(posedge clk);
                #1 flush = 0;
            end
        join
        mrsp_delay = 0;
        chk("flush_mid_miss_rsp", h, 0);
        model_flush();
        req_tag = 16'h10;
        req_valid = 1;
        @(negedge clk);
        chk("flush_pend_blocks_req", req_ready, 0);
        chk("flush_done_not_yet", flush_done, 0);
        @(negedge clk);
        chk("flush_done_pulse", flush_done, 1);
        chk("flush_blocks_req", req_ready, 0);
        do_req(16'h10, 0, h, d);
        chk("post_flush_miss", h, 0);

        chk_en = 0;
        mreq_delay = 20;
        req_tag = 16'h30;
        req_valid = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        @(posedge clk);
        #1 req_valid = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req_valid && n < 50);
        chk("mreq_before_reset", mem_req_tag, 16'h30);
        @(posedge clk);
        #1 rstn = 0;
        @(posedge clk);
        #1 rstn = 1;
        model_flush();
        hc = 0;
        mc = 0;
        @(negedge clk);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_mem_req", mem_req_valid, 0);
        chk("midrst_hit_cnt", hit_cnt, 0);
        chk("midrst_miss_cnt", miss_cnt, 0);
        repeat (25) @(posedge clk);
        #1;
        mreq_delay = 0;
        chk_en = 1;
        do_req(16'h10, 0, h, d);
        chk("after_reset_miss", h, 0);
        chk("after_reset_miss_cnt", miss_cnt, 1);

        for (int i = 0; i < 17; i++) do_req(16'h100 + 16'(i), 0, h, d);
        chk("miss_cnt_saturated", miss_cnt, 4'hF);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                @(posedge clk);
                #1 flush = 1;
                @(posedge clk);
                #1 flush = 0;
                model_flush();
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!flush_done && n < 10);
                chk("rand_flush_done", flush_done, 1);
            end
            mreq_delay = $urandom_range(0, 3);
            mrsp_delay = $urandom_range(0, 3);
            do_req(16'h10 + 16'($urandom_range(0, 11)), $urandom_range(0, 2), h, d);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
